// File: rtl/muldiv_sequencer_if.sv
// Execute-stage handshake between the pipeline and the iterative multiply/divide engine.
// The pipeline side holds start/operands until done; the engine answers with stall/done/result.
interface muldiv_sequencer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start_i;
  logic [2:0]            funct3_i;
  logic [DATA_WIDTH-1:0] rs1_i;
  logic [DATA_WIDTH-1:0] rs2_i;
  logic                  flush_i;
  logic                  stall_o;
  logic                  done_o;
  logic [DATA_WIDTH-1:0] result_o;

  modport master (
    output start_i, funct3_i, rs1_i, rs2_i, flush_i,
    input  stall_o, done_o, result_o
  );

  modport slave (
    input  start_i, funct3_i, rs1_i, rs2_i, flush_i,
    output stall_o, done_o, result_o
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide: 1 accept cycle + 32 CALC steps, result one cycle in DONE.
// Stalls the pipeline while busy; divide-by-zero and signed overflow finish after 1 stall cycle.
module muldiv_sequencer #(
  parameter int DATA_WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  muldiv_sequencer_if.slave  bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic            neg_q, neg_d;
  logic [W:0]      m_q, m_d;
  logic [2*W:0]    acc_q, acc_d;
  logic [W-1:0]    res_q, res_d;

  logic            a_sgn, b_sgn, sa, sb, div_zero, div_ovf;
  logic [W:0]      ma, mb;
  logic [W:0]      mul_sum, div_shift, div_rem;
  logic            div_ge;
  logic [2*W:0]    mul_next, div_next, step_acc;
  logic [2*W-1:0]  prod;
  logic [W-1:0]    quo, rem, fin;

  // Signedness of each operand by opcode; MULHSU keeps rs2 unsigned.
  always_comb begin
    a_sgn    = bus.funct3_i[2] ? ~bus.funct3_i[0] : (bus.funct3_i[1:0] != 2'b11);
    b_sgn    = bus.funct3_i[2] ? ~bus.funct3_i[0] : ~bus.funct3_i[1];
    sa       = a_sgn & bus.rs1_i[W-1];
    sb       = b_sgn & bus.rs2_i[W-1];
    ma       = {1'b0, sa ? -bus.rs1_i : bus.rs1_i};
    mb       = {1'b0, sb ? -bus.rs2_i : bus.rs2_i};
    div_zero = bus.funct3_i[2] & (bus.rs2_i == '0);
    div_ovf  = bus.funct3_i[2] & ~bus.funct3_i[0] &
               (bus.rs1_i == {1'b1, {(W-1){1'b0}}}) & (bus.rs2_i == '1);
  end

  // One iteration: shift-add multiply or restoring divide sharing the accumulator.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*W-1:W]} + m_q;
    mul_next  = acc_q[0] ? ({mul_sum, acc_q[W-1:0]} >> 1) : (acc_q >> 1);
    div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
    div_ge    = (div_shift >= m_q);
    div_rem   = div_ge ? (div_shift - m_q) : div_shift;
    div_next  = {div_rem, acc_q[W-2:0], div_ge};
    step_acc  = op_q[2] ? div_next : mul_next;

    prod = neg_q ? -step_acc[2*W-1:0] : step_acc[2*W-1:0];
    quo  = neg_q ? -step_acc[W-1:0]   : step_acc[W-1:0];
    rem  = neg_q ? -step_acc[2*W-1:W] : step_acc[2*W-1:W];
    if (op_q[2])
      fin = op_q[1] ? rem : quo;
    else
      fin = (op_q[1:0] == 2'b00) ? prod[W-1:0] : prod[2*W-1:W];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_d   = neg_q;
    m_d     = m_q;
    acc_d   = acc_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start_i && !bus.flush_i) begin
          op_d = bus.funct3_i;
          if (div_zero) begin
            res_d   = bus.funct3_i[1] ? bus.rs1_i : '1;
            state_d = DONE;
          end else if (div_ovf) begin
            res_d   = bus.funct3_i[1] ? '0 : bus.rs1_i;
            state_d = DONE;
          end else begin
            neg_d   = (bus.funct3_i[2] & bus.funct3_i[1]) ? sa : (sa ^ sb);
            m_d     = bus.funct3_i[2] ? mb : ma;
            acc_d   = {{(W+1){1'b0}}, bus.funct3_i[2] ? ma[W-1:0] : mb[W-1:0]};
            cnt_d   = CW'(W-1);
            state_d = CALC;
          end
        end
      end
      CALC: begin
        if (bus.flush_i) begin
          state_d = IDLE;
        end else begin
          acc_d = step_acc;
          if (cnt_q == '0) begin
            res_d   = fin;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      neg_q   <= 1'b0;
      m_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
    end
  end

  assign bus.stall_o  = ((state_q == IDLE) & bus.start_i & ~bus.flush_i) | (state_q == CALC);
  assign bus.done_o   = (state_q == DONE) & ~bus.flush_i;
  assign bus.result_o = res_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: hand-computed RV32M results, stall lengths, flush and async reset.
module tb_muldiv_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  muldiv_sequencer_if #(.DATA_WIDTH(32)) bus_if ();

  muldiv_sequencer #(.DATA_WIDTH(32)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus_if)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drives one op at the current (post-negedge) point and follows it to DONE.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_stall);
    int          stalls;
    logic        seen;
    logic [31:0] res;
    logic        stall_in_done;
    stalls        = 0;
    seen          = 1'b0;
    res           = '0;
    stall_in_done = 1'b0;
    bus_if.funct3_i = f;
    bus_if.rs1_i    = a;
    bus_if.rs2_i    = b;
    bus_if.start_i  = 1'b1;
    for (int i = 0; i < 60 && !seen; i++) begin
      #1;
      if (bus_if.done_o) begin
        seen          = 1'b1;
        res           = bus_if.result_o;
        stall_in_done = bus_if.stall_o;
      end else begin
        if (bus_if.stall_o) stalls++;
        @(negedge clk);
      end
    end
    chk({tag, "_done"}, 32'(seen), 32'd1);
    chk({tag, "_res"}, res, exp);
    chk({tag, "_stall"}, 32'(stalls), 32'(exp_stall));
    chk({tag, "_stall_in_done"}, 32'(stall_in_done), 32'd0);
    bus_if.start_i = 1'b0;
    @(negedge clk);
    #1;
    chk({tag, "_done_1cyc"}, 32'(bus_if.done_o), 32'd0);
  endtask

  initial begin
    int dn;
    bus_if.start_i  = 1'b0;
    bus_if.funct3_i = 3'd0;
    bus_if.rs1_i    = '0;
    bus_if.rs2_i    = '0;
    bus_if.flush_i  = 1'b0;

    #12;
    chk("rst_stall", 32'(bus_if.stall_o), 32'd0);
    chk("rst_done", 32'(bus_if.done_o), 32'd0);
    chk("rst_result", bus_if.result_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;

    run_op("mul_neg",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    run_op("mulh_min",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33);
    run_op("mulhu_min",  3'b011, 32'h80000000, 32'h80000000, 32'h40000000, 33);
    run_op("mulhsu_min", 3'b010, 32'h80000000, 32'h80000000, 32'hC0000000, 33);
    run_op("mulhu_max",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    run_op("div_neg",    3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
    run_op("rem_neg",    3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
    run_op("divu",       3'b101, 32'd100,      32'd7,        32'd14,       33);
    run_op("remu",       3'b111, 32'd100,      32'd7,        32'd2,        33);
    run_op("rem_negdvs", 3'b110, 32'd7,        32'hFFFFFFFE, 32'd1,        33);
    run_op("div_min2",   3'b100, 32'h80000000, 32'd2,        32'hC0000000, 33);
    run_op("divu_max",   3'b101, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 33);
    run_op("divu_z",     3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    run_op("rem_z",      3'b110, 32'd5,        32'd0,        32'd5,        1);
    run_op("remu_z",     3'b111, 32'hDEADBEEF, 32'd0,        32'hDEADBEEF, 1);
    run_op("div_ovf",    3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("rem_ovf",    3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);

    // Squash on the 10th CALC cycle.
    bus_if.funct3_i = 3'b101;
    bus_if.rs1_i    = 32'd9;
    bus_if.rs2_i    = 32'd3;
    bus_if.start_i  = 1'b1;
    @(negedge clk);
    repeat (9) @(negedge clk);
    #1;
    chk("flush_pre_stall", 32'(bus_if.stall_o), 32'd1);
    bus_if.flush_i = 1'b1;
    bus_if.start_i = 1'b0;
    @(negedge clk);
    bus_if.flush_i = 1'b0;
    #1;
    chk("flush_stall", 32'(bus_if.stall_o), 32'd0);
    chk("flush_done", 32'(bus_if.done_o), 32'd0);
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (bus_if.done_o) dn++;
    end
    chk("flush_no_done", 32'(dn), 32'd0);
    run_op("divu_after_flush", 3'b101, 32'd9, 32'd3, 32'd3, 33);

    // Asynchronous reset in the middle of a multiply.
    bus_if.funct3_i = 3'b000;
    bus_if.rs1_i    = 32'd5;
    bus_if.rs2_i    = 32'd5;
    bus_if.start_i  = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    chk("pre_rst_stall", 32'(bus_if.stall_o), 32'd1);
    bus_if.start_i = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_stall", 32'(bus_if.stall_o), 32'd0);
    chk("arst_done", 32'(bus_if.done_o), 32'd0);
    chk("arst_result", bus_if.result_o, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    run_op("mul_after_rst", 3'b000, 32'd3, 32'd4, 32'd12, 33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
